// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction-fetch front end.
//   INSTR_W   : instruction width fetched from imem
//   br_mode_t : redirect target selection (cond imm19, uncond imm26, register)
// ---------------------------------------------------------------------------
package fetch_pkg;

    localparam int INSTR_W = 32;

    typedef enum logic [1:0] {
        BR_COND   = 2'b00,
        BR_UNCOND = 2'b01,
        BR_REG    = 2'b10
    } br_mode_t;

    // Bit 1 set selects the register target; this also folds the unused
    // 2'b11 encoding onto BR_REG.
    function automatic logic is_reg_mode(input br_mode_t mode);
        return mode[1];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// DEPTH-entry synchronous FIFO with flush, used as the fetch queue.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_push       : write i_data at the tail
//   i_data       : W-bit entry
//   i_pop        : drop the head (ignored when empty)
//   i_flush      : empty the queue; overrides push and pop
//   o_head       : head entry (combinational read of the head slot)
//   o_valid      : queue non-empty
//   o_count      : number of stored entries
// ---------------------------------------------------------------------------
module fetch_fifo #(
    parameter int W     = 96,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [W-1:0]             i_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [W-1:0]             o_head,
    output logic                     o_valid,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic [W-1:0]  w_entries [DEPTH];
    logic          w_push;
    logic          w_pop;

    assign o_valid = (r_count != '0);
    assign o_count = r_count;
    assign w_push  = i_push && !i_flush;
    assign w_pop   = i_pop && o_valid && !i_flush;

    // Storage slots are reset so the head reads as zero out of reset.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [W-1:0] r_data;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_data <= '0;
                end else if (w_push && (r_wr_ptr == PW'(gi))) begin
                    r_data <= i_data;
                end
            end
            assign w_entries[gi] = r_data;
        end
    endgenerate

    assign o_head = w_entries[r_rd_ptr];

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_queue_unit.sv
// ---------------------------------------------------------------------------
// fetch_queue_unit
// Instruction-fetch front end: owns the PC, issues sequential fetches to a
// 1-cycle synchronous imem, buffers {pc,instr} pairs and serves decode over
// valid/ready. Branch redirects reload the PC and flush the queue.
// Ports:
//   clk, reset        : clock, asynchronous active-low reset
//   imem_req/addr     : fetch request and address (address is the PC)
//   imem_rdata        : instruction, valid the cycle after imem_req
//   out_valid/ready   : decode handshake; out_instr/out_pc are the head
//   br_taken/br_mode  : redirect request and target selection
//   br_pc, imm26,     : target operands (offsets in words)
//   imm19, br_reg
//   align_err         : one-cycle pulse, register target was misaligned
// ---------------------------------------------------------------------------
module fetch_queue_unit
    import fetch_pkg::*;
#(
    parameter int               ADDR_W   = 64,
    parameter int               DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [INSTR_W-1:0]  out_instr,
    output logic [ADDR_W-1:0]   out_pc,
    input  logic                br_taken,
    input  br_mode_t            br_mode,
    input  logic [ADDR_W-1:0]   br_pc,
    input  logic [25:0]         imm26,
    input  logic [18:0]         imm19,
    input  logic [ADDR_W-1:0]   br_reg,
    output logic                align_err
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0]          r_pc;
    logic [ADDR_W-1:0]          r_addr_d1;
    logic                       r_inflight;
    logic                       r_align_err;

    logic [CW-1:0]              w_count;
    logic [CW:0]                w_outstanding;
    logic                       w_issue;
    logic                       w_push;
    logic                       w_pop;
    logic [ADDR_W-1:0]          w_off19;
    logic [ADDR_W-1:0]          w_off26;
    logic [ADDR_W-1:0]          w_target;
    logic [ADDR_W+INSTR_W-1:0]  w_head;

    // Word offsets sign-extended and scaled to bytes.
    assign w_off19 = {{(ADDR_W-21){imm19[18]}}, imm19, 2'b00};
    assign w_off26 = {{(ADDR_W-28){imm26[25]}}, imm26, 2'b00};

    always_comb begin
        w_target = {br_reg[ADDR_W-1:2], 2'b00};
        case (br_mode)
            BR_COND:   w_target = br_pc + w_off19;
            BR_UNCOND: w_target = br_pc + w_off26;
            default:   w_target = {br_reg[ADDR_W-1:2], 2'b00};
        endcase
    end

    // Credit check counts the in-flight response as occupying a slot, so a
    // response always finds room. A pop in the same cycle is not credited.
    // The reset term keeps imem_req low while reset is held.
    assign w_outstanding = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
    assign w_issue = reset && !br_taken && (w_outstanding < (CW+1)'(DEPTH));

    // A redirect discards the response arriving this cycle and blocks any pop.
    assign w_push = r_inflight && !br_taken;
    assign w_pop  = out_valid && out_ready && !br_taken;

    assign imem_req  = w_issue;
    assign imem_addr = r_pc;
    assign align_err = r_align_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc        <= RESET_PC;
            r_addr_d1   <= '0;
            r_inflight  <= 1'b0;
            r_align_err <= 1'b0;
        end else begin
            r_inflight  <= w_issue;
            r_align_err <= br_taken && is_reg_mode(br_mode) && (br_reg[1:0] != 2'b00);
            if (w_issue) begin
                r_addr_d1 <= r_pc;
            end
            if (br_taken) begin
                r_pc <= w_target;
            end else if (w_issue) begin
                r_pc <= r_pc + ADDR_W'(4);
            end
        end
    end

    fetch_fifo #(
        .W     (ADDR_W + INSTR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (w_push),
        .i_data  ({r_addr_d1, imem_rdata}),
        .i_pop   (w_pop),
        .i_flush (br_taken),
        .o_head  (w_head),
        .o_valid (out_valid),
        .o_count (w_count)
    );

    assign out_instr = w_head[INSTR_W-1:0];
    assign out_pc    = w_head[ADDR_W+INSTR_W-1:INSTR_W];

endmodule
